apb_initiator: RTL and testbench
================================

APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 Parameter: TIMEOUT, 16, maximum number of ACCESS cycles with pready_i low before the transfer is aborted; legal range 2..255.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: cmd_valid_i  input  1  command request from the local host.
REQ-005 Port: cmd_ready_o  output  1  command accepted on a cycle where cmd_valid_i and cmd_ready_o are both high.
REQ-006 Port: cmd_write_i  input  1  1 = write, 0 = read.
REQ-007 Port: cmd_addr_i  input  12  byte address.
REQ-008 Port: cmd_wdata_i  input  32  write data.
REQ-009 Port: cmd_strb_i  input  4  write byte strobes.
REQ-010 Port: rsp_valid_o  output  1  response available.
REQ-011 Port: rsp_ready_i  input  1  host consumes the response.
REQ-012 Port: rsp_rdata_o  output  32  read data; 0 for writes and for aborted transfers.
REQ-013 Port: rsp_error_o  output  1  pslverr_i seen, or timeout.
REQ-014 Port: rsp_timeout_o  output  1  transfer aborted by timeout.
REQ-015 Port: psel_o, penable_o, pwrite_o  output  1 each  APB control.
REQ-016 Port: paddr_o  output  12  APB address.
REQ-017 Port: pwdata_o  output  32  APB write data.
REQ-018 Port: pstrb_o  output  4  APB strobes.
REQ-019 Port: pready_i, pslverr_i  input  1 each  completer handshake and error.
REQ-020 Port: prdata_i  input  32  completer read data.

Function
REQ-021 The FSM SHALL have states IDLE, SETUP, ACCESS and RESP, and every APB and response output SHALL be driven directly from registers.
REQ-022 cmd_ready_o SHALL be high only in IDLE; a handshake SHALL capture write, addr, wdata and strb, and move IDLE->SETUP.
REQ-023 SETUP SHALL drive psel_o=1 and penable_o=0 for exactly one cycle, then move to ACCESS.
REQ-024 ACCESS SHALL drive psel_o=1 and penable_o=1; paddr_o, pwrite_o, pwdata_o and pstrb_o SHALL stay stable from SETUP until the transfer ends.
REQ-025 For reads, pwdata_o SHALL be 0 and pstrb_o SHALL be 4'b0000; for writes, cmd_strb_i SHALL pass through unchanged, including 4'b0000.
REQ-026 In ACCESS with pready_i=1, on that edge the block SHALL:
- capture rsp_rdata_o (prdata_i for reads, 0 for writes);
- set rsp_error_o=pslverr_i and rsp_timeout_o=0;
- drop psel_o/penable_o;
- move to RESP.
REQ-027 A wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with pready_i=0.
REQ-028 When the wait counter reaches TIMEOUT, on that edge the block SHALL:
- drop psel_o/penable_o;
- set rsp_error_o=1, rsp_timeout_o=1 and rsp_rdata_o=0;
- move to RESP.
REQ-029 If pready_i=1 on the cycle the timeout would fire, pready_i SHALL win and the transfer SHALL complete normally.
REQ-030 RESP SHALL hold rsp_valid_o=1 and stable response fields until rsp_ready_i=1, then move to IDLE; there SHALL be no bypass, so a new command can be accepted one cycle later at the earliest.
REQ-031 Latency: handshake at edge N -> SETUP in cycle N+1 -> ACCESS in cycle N+2 -> with zero wait states, rsp_valid_o=1 in cycle N+3.
REQ-032 pslverr_i and prdata_i SHALL be ignored in every cycle other than ACCESS with pready_i=1.
REQ-033 psel_o and penable_o SHALL never be high outside SETUP/ACCESS, and penable_o SHALL never be high without psel_o.

Reset
REQ-034 Asserting reset_n low SHALL immediately force:
- state=IDLE, wait counter=0;
- psel_o=penable_o=pwrite_o=0;
- paddr_o=0, pwdata_o=0, pstrb_o=0;
- rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=rsp_timeout_o=0.
REQ-035 Consequences of reset:
- reset mid-transfer SHALL abort the transfer with no response issued;
- cmd_ready_o SHALL be 1 in the first cycle after release.

Verification
REQ-036 Write with zero wait states: addr 0x008, wdata 0x0000_001B, strb 4'b1111 -> SETUP then ACCESS; rsp_valid_o in cycle N+3; rsp_error_o=0, rsp_rdata_o=0.
REQ-037 Read of 0x010 with pready_i low for 3 cycles and prdata_i=0x0000_0005 -> penable_o high for 4 cycles; rsp_rdata_o=0x5; paddr_o stable throughout.
REQ-038 Read with pslverr_i=1 at completion -> rsp_error_o=1, rsp_timeout_o=0.
REQ-039 pready_i held low with TIMEOUT=16 -> abort after 16 ACCESS cycles; rsp_error_o=1, rsp_timeout_o=1, rsp_rdata_o=0x0; a second run with pready_i=1 on the 16th cycle -> normal completion.
REQ-040 Back-pressure: rsp_ready_i low for 5 cycles while cmd_valid_i stays high -> cmd_ready_o=0 and response fields stable; accept the next command the cycle after rsp_ready_i=1.
REQ-041 Reset asserted in ACCESS -> psel_o, penable_o and rsp_valid_o low immediately; no response after release; next command completes normally.

Source files
------------

// File: rtl/apb_initiator_if.sv
// Host command/response channel and APB requester bus of apb_initiator.
// The master modport is the initiator's view; slave is the host/completer side.
interface apb_initiator_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [11:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_strb_i;

  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_error_o;
  logic        rsp_timeout_o;

  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [11:0] paddr_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic        pready_i;
  logic        pslverr_i;
  logic [31:0] prdata_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
    input  rsp_ready_i, pready_i, pslverr_i, prdata_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o, rsp_timeout_o,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
    output rsp_ready_i, pready_i, pslverr_i, prdata_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o, rsp_timeout_o,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o
  );
endinterface

// File: rtl/apb_initiator.sv
// Single-outstanding APB initiator: one host command -> one APB transfer -> one response.
// All APB and response outputs come straight from registers; ACCESS aborts after TIMEOUT waits.
module apb_initiator #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  apb_initiator_if.master  bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // ACCESS cycle k sees wait_q == k-1, so the abort fires on the TIMEOUT-th cycle.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [11:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [3:0]  pstrb_q, pstrb_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;
  logic        rsp_timeout_q, rsp_timeout_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      wait_q        <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          pwrite_d  = bus.cmd_write_i;
          paddr_d   = bus.cmd_addr_i;
          pwdata_d  = bus.cmd_write_i ? bus.cmd_wdata_i : '0;
          pstrb_d   = bus.cmd_write_i ? bus.cmd_strb_i  : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        wait_d    = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // pready wins over a timeout landing on the same cycle
        if (bus.pready_i) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : bus.prdata_i;
          rsp_error_d   = bus.pslverr_i;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (wait_q == WAIT_LAST) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_error_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready_o   = (state_q == IDLE);
  assign bus.psel_o        = psel_q;
  assign bus.penable_o     = penable_q;
  assign bus.pwrite_o      = pwrite_q;
  assign bus.paddr_o       = paddr_q;
  assign bus.pwdata_o      = pwdata_q;
  assign bus.pstrb_o       = pstrb_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_rdata_o   = rsp_rdata_q;
  assign bus.rsp_error_o   = rsp_error_q;
  assign bus.rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Self-checking bench for apb_initiator: expected responses are queued when a command
// is issued and popped when the DUT presents the response.
module tb_apb_initiator;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        timeout;
  } rsp_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  rsp_t sb[$];
  rsp_t exp;

  apb_initiator_if bus ();

  apb_initiator #(.TIMEOUT(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned n;
    n = 0;
    bus.cmd_write_i = w;
    bus.cmd_addr_i  = a;
    bus.cmd_wdata_i = d;
    bus.cmd_strb_i  = s;
    bus.cmd_valid_i = 1'b1;
    while (bus.cmd_ready_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL cmd_handshake: cmd_ready_o never rose within 50 cycles");
    end
    tick();
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp();
    int unsigned n;
    n = 0;
    while (bus.rsp_valid_o !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL rsp_wait: rsp_valid_o never rose within 60 cycles");
    end
  endtask

  task automatic test_reset();
    bus.cmd_valid_i = 1'b0; bus.cmd_write_i = 1'b0; bus.cmd_addr_i = '0;
    bus.cmd_wdata_i = '0;   bus.cmd_strb_i = '0;    bus.rsp_ready_i = 1'b1;
    bus.pready_i = 1'b1;    bus.pslverr_i = 1'b0;   bus.prdata_i = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.psel_o, bus.penable_o, bus.pwrite_o, bus.paddr_o, bus.pwdata_o, bus.pstrb_o,
         bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: psel=%b pen=%b pwr=%b paddr=%h pwdata=%h pstrb=%b rv=%b rd=%h re=%b rt=%b, expected all zero",
               bus.psel_o, bus.penable_o, bus.pwrite_o, bus.paddr_o, bus.pwdata_o, bus.pstrb_o,
               bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o);
    end
    tick(); tick();
    reset_n = 1'b1;
    checks++;
    if (bus.cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready_o);
    end
  endtask

  task automatic test_write_zero_wait();
    bus.pready_i = 1'b1;
    sb.push_back('{rdata: 32'h0, error: 1'b0, timeout: 1'b0});
    send_cmd(1'b1, 12'h008, 32'h0000_001B, 4'b1111);
    // cycle N+1: SETUP
    checks++;
    if ({bus.psel_o, bus.penable_o, bus.pwrite_o, bus.paddr_o, bus.pwdata_o, bus.pstrb_o, bus.rsp_valid_o}
        !== {1'b1, 1'b0, 1'b1, 12'h008, 32'h0000_001B, 4'b1111, 1'b0}) begin
      errors++;
      $display("FAIL wr_setup: psel=%b pen=%b pwr=%b paddr=%h pwdata=%h pstrb=%b rv=%b, expected 1 0 1 008 0000001b 1111 0",
               bus.psel_o, bus.penable_o, bus.pwrite_o, bus.paddr_o, bus.pwdata_o, bus.pstrb_o, bus.rsp_valid_o);
    end
    tick();
    checks++;
    if ({bus.psel_o, bus.penable_o, bus.paddr_o, bus.cmd_ready_o, bus.rsp_valid_o} !== {1'b1, 1'b1, 12'h008, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wr_access: psel=%b pen=%b paddr=%h crdy=%b rv=%b, expected 1 1 008 0 0",
               bus.psel_o, bus.penable_o, bus.paddr_o, bus.cmd_ready_o, bus.rsp_valid_o);
    end
    tick();
    checks++;
    if ({bus.rsp_valid_o, bus.psel_o, bus.penable_o} !== 3'b100) begin
      errors++;
      $display("FAIL wr_latency: rv=%b psel=%b pen=%b in cycle N+3, expected 1 0 0",
               bus.rsp_valid_o, bus.psel_o, bus.penable_o);
    end
    exp = sb.pop_front();
    checks++;
    if ({bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o} !== exp) begin
      errors++;
      $display("FAIL wr_rsp: got rdata=%h err=%b to=%b expected rdata=%h err=%b to=%b",
               bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o, exp.rdata, exp.error, exp.timeout);
    end
    tick();
  endtask

  task automatic test_read_wait();
    bus.pready_i = 1'b0;
    sb.push_back('{rdata: 32'h0000_0005, error: 1'b0, timeout: 1'b0});
    send_cmd(1'b0, 12'h010, 32'hDEAD_BEEF, 4'b1111);
    checks++;
    if ({bus.pwrite_o, bus.pwdata_o, bus.pstrb_o} !== {1'b0, 32'h0, 4'b0000}) begin
      errors++;
      $display("FAIL rd_setup_fields: pwr=%b pwdata=%h pstrb=%b expected 0 00000000 0000",
               bus.pwrite_o, bus.pwdata_o, bus.pstrb_o);
    end
    // garbage on prdata/pslverr while waiting must be ignored
    bus.pslverr_i = 1'b1;
    bus.prdata_i  = 32'h0BAD_0BAD;
    tick();
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if ({bus.psel_o, bus.penable_o, bus.paddr_o, bus.rsp_valid_o} !== {1'b1, 1'b1, 12'h010, 1'b0}) begin
        errors++;
        $display("FAIL rd_wait_cycle%0d: psel=%b pen=%b paddr=%h rv=%b expected 1 1 010 0",
                 c, bus.psel_o, bus.penable_o, bus.paddr_o, bus.rsp_valid_o);
      end
      if (c == 4) begin
        bus.pready_i  = 1'b1;
        bus.pslverr_i = 1'b0;
        bus.prdata_i  = 32'h0000_0005;
      end
      tick();
    end
    bus.prdata_i = 32'h0000_0099;
    checks++;
    if ({bus.rsp_valid_o, bus.penable_o} !== 2'b10) begin
      errors++;
      $display("FAIL rd_wait_end: rv=%b pen=%b expected 1 0", bus.rsp_valid_o, bus.penable_o);
    end
    exp = sb.pop_front();
    checks++;
    if ({bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o} !== exp) begin
      errors++;
      $display("FAIL rd_rsp: got rdata=%h err=%b to=%b expected rdata=%h err=%b to=%b",
               bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o, exp.rdata, exp.error, exp.timeout);
    end
    tick();
  endtask

  task automatic test_slverr();
    bus.pready_i = 1'b1;
    sb.push_back('{rdata: 32'h0000_1234, error: 1'b1, timeout: 1'b0});
    send_cmd(1'b0, 12'h044, 32'h0, 4'b0000);
    bus.pslverr_i = 1'b1;
    bus.prdata_i  = 32'h0000_1234;
    wait_rsp();
    bus.pslverr_i = 1'b0;
    exp = sb.pop_front();
    checks++;
    if ({bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o} !== exp) begin
      errors++;
      $display("FAIL slverr_rsp: got rdata=%h err=%b to=%b expected rdata=%h err=%b to=%b",
               bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o, exp.rdata, exp.error, exp.timeout);
    end
    tick();
  endtask

  task automatic test_timeout();
    int unsigned cnt;
    bus.pready_i = 1'b0;
    bus.prdata_i = 32'hFFFF_FFFF;
    sb.push_back('{rdata: 32'h0, error: 1'b1, timeout: 1'b1});
    send_cmd(1'b0, 12'h0A4, 32'h0, 4'b0000);
    tick();
    cnt = 0;
    while (bus.penable_o === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 16 || bus.rsp_valid_o !== 1'b1 || bus.psel_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_cycles: access cycles=%0d rv=%b psel=%b expected 16 1 0",
               cnt, bus.rsp_valid_o, bus.psel_o);
    end
    exp = sb.pop_front();
    checks++;
    if ({bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o} !== exp) begin
      errors++;
      $display("FAIL timeout_rsp: got rdata=%h err=%b to=%b expected rdata=%h err=%b to=%b",
               bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o, exp.rdata, exp.error, exp.timeout);
    end
    tick();
    // pready arriving on the 16th ACCESS cycle must win over the timeout
    sb.push_back('{rdata: 32'h0000_0077, error: 1'b0, timeout: 1'b0});
    send_cmd(1'b0, 12'h0A8, 32'h0, 4'b0000);
    tick();
    for (int c = 1; c < 16; c++) tick();
    checks++;
    if ({bus.penable_o, bus.rsp_valid_o} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_edge_access16: pen=%b rv=%b expected 1 0", bus.penable_o, bus.rsp_valid_o);
    end
    bus.pready_i = 1'b1;
    bus.prdata_i = 32'h0000_0077;
    tick();
    exp = sb.pop_front();
    checks++;
    if ({bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL timeout_edge_rsp: got rv=%b rdata=%h err=%b to=%b expected rv=1 rdata=%h err=%b to=%b",
               bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o, exp.rdata, exp.error, exp.timeout);
    end
    tick();
  endtask

  task automatic test_back_pressure();
    bus.pready_i    = 1'b1;
    bus.prdata_i    = 32'hA5A5_0001;
    bus.rsp_ready_i = 1'b0;
    sb.push_back('{rdata: 32'hA5A5_0001, error: 1'b0, timeout: 1'b0});
    send_cmd(1'b0, 12'h0C0, 32'h0, 4'b0000);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = 1'b0;
    bus.cmd_addr_i  = 12'h020;
    tick();
    tick();
    exp = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      bus.prdata_i  = 32'h1111_0000 + 32'(c);
      bus.pslverr_i = 1'(c);
      checks++;
      if ({bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o} !== {1'b0, 1'b1, exp}) begin
        errors++;
        $display("FAIL bp_hold%0d: crdy=%b rv=%b rdata=%h err=%b to=%b expected crdy=0 rv=1 rdata=%h err=%b to=%b",
                 c, bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o,
                 exp.rdata, exp.error, exp.timeout);
      end
      tick();
    end
    bus.pslverr_i   = 1'b0;
    bus.prdata_i    = 32'h0000_0055;
    bus.rsp_ready_i = 1'b1;
    tick();
    checks++;
    if ({bus.cmd_ready_o, bus.rsp_valid_o} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release: crdy=%b rv=%b expected 1 0", bus.cmd_ready_o, bus.rsp_valid_o);
    end
    sb.push_back('{rdata: 32'h0000_0055, error: 1'b0, timeout: 1'b0});
    tick();
    bus.cmd_valid_i = 1'b0;
    checks++;
    if ({bus.psel_o, bus.penable_o, bus.pwrite_o, bus.paddr_o} !== {1'b1, 1'b0, 1'b0, 12'h020}) begin
      errors++;
      $display("FAIL bp_next_setup: psel=%b pen=%b pwr=%b paddr=%h expected 1 0 0 020",
               bus.psel_o, bus.penable_o, bus.pwrite_o, bus.paddr_o);
    end
    wait_rsp();
    exp = sb.pop_front();
    checks++;
    if ({bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o} !== exp) begin
      errors++;
      $display("FAIL bp_next_rsp: got rdata=%h err=%b to=%b expected rdata=%h err=%b to=%b",
               bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o, exp.rdata, exp.error, exp.timeout);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.pready_i = 1'b0;
    sb.push_back('{rdata: 32'h0, error: 1'b0, timeout: 1'b0});
    send_cmd(1'b0, 12'h3FC, 32'h0, 4'b0000);
    tick();
    checks++;
    if (bus.penable_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_in_access: pen=%b expected 1", bus.penable_o);
    end
    #2 reset_n = 1'b0;
    #1;
    void'(sb.pop_back());
    checks++;
    if ({bus.psel_o, bus.penable_o, bus.rsp_valid_o} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_async: psel=%b pen=%b rv=%b expected 0 0 0",
               bus.psel_o, bus.penable_o, bus.rsp_valid_o);
    end
    bus.pready_i = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({bus.rsp_valid_o, bus.psel_o, bus.cmd_ready_o} !== 3'b001) begin
        errors++;
        $display("FAIL rstmid_quiet%0d: rv=%b psel=%b crdy=%b expected 0 0 1",
                 c, bus.rsp_valid_o, bus.psel_o, bus.cmd_ready_o);
      end
      tick();
    end
    sb.push_back('{rdata: 32'h0, error: 1'b0, timeout: 1'b0});
    send_cmd(1'b1, 12'h004, 32'h0000_0009, 4'b0000);
    checks++;
    if ({bus.pwrite_o, bus.paddr_o, bus.pwdata_o, bus.pstrb_o} !== {1'b1, 12'h004, 32'h0000_0009, 4'b0000}) begin
      errors++;
      $display("FAIL rstmid_next_setup: pwr=%b paddr=%h pwdata=%h pstrb=%b expected 1 004 00000009 0000",
               bus.pwrite_o, bus.paddr_o, bus.pwdata_o, bus.pstrb_o);
    end
    bus.prdata_i = 32'hFFFF_0000;
    wait_rsp();
    exp = sb.pop_front();
    checks++;
    if ({bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o} !== exp) begin
      errors++;
      $display("FAIL rstmid_next_rsp: got rdata=%h err=%b to=%b expected rdata=%h err=%b to=%b",
               bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o, exp.rdata, exp.error, exp.timeout);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_pressure();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
